// File: rtl/anc_pkg.sv
// Shared types and default constants for the ANC LMS adaptation sequencer.
package anc_pkg;

    localparam int DATA_BUS_SIZE_DEF = 11;
    localparam int TAPS_DEF          = 3;
    localparam int SAT_LIMIT_DEF     = 1000;
    localparam int ERR_TIMEOUT_DEF   = 15;

    // One coefficient component in Qn.10 fixed point at the default width.
    typedef logic signed [DATA_BUS_SIZE_DEF-1:0] coeff_t;

    // Per-sample sequencing states.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_ERR = 3'd1,
        ADAPT    = 3'd2,
        CAPTURE  = 3'd3,
        COMMIT   = 3'd4
    } seq_state_e;

endpackage

// File: rtl/anc_coeff_sat_check.sv
// Combinational saturation guard: flags when any candidate I/Q component
// has magnitude >= SAT_LIMIT. The most negative code always counts as
// saturated, because its magnitude cannot be represented at DATA_BUS_SIZE.
module anc_coeff_sat_check
    import anc_pkg::*;
#(
    parameter int DATA_BUS_SIZE = DATA_BUS_SIZE_DEF,
    parameter int TAPS          = TAPS_DEF,
    parameter int SAT_LIMIT     = SAT_LIMIT_DEF
) (
    input  logic signed [DATA_BUS_SIZE-1:0] coeff_i [TAPS],
    input  logic signed [DATA_BUS_SIZE-1:0] coeff_q [TAPS],
    output logic                            saturated
);

    // Magnitude is computed one bit wider so the most negative code does not wrap.
    localparam int MW = DATA_BUS_SIZE + 1;
    localparam logic [MW-1:0] LIMIT = MW'(SAT_LIMIT);

    function automatic logic is_sat(input logic signed [DATA_BUS_SIZE-1:0] x);
        logic [MW-1:0] ext_v;
        logic [MW-1:0] mag_v;
        logic          most_neg_v;
        ext_v      = {x[DATA_BUS_SIZE-1], x};
        mag_v      = x[DATA_BUS_SIZE-1] ? (~ext_v + MW'(1)) : ext_v;
        most_neg_v = (x == {1'b1, {(DATA_BUS_SIZE-1){1'b0}}});
        return (mag_v >= LIMIT) | most_neg_v;
    endfunction

    // OR the per-component test across all 2*TAPS candidate values.
    always_comb begin
        saturated = 1'b0;
        for (int t = 0; t < TAPS; t++) begin
            saturated = saturated | is_sat(coeff_i[t]) | is_sat(coeff_q[t]);
        end
    end

endmodule

// File: rtl/anc_adapt_sequencer.sv
// Per-sample controller for the ANC LMS adaptation path. Owns the complex
// coefficient bank, pulses the adaptation enable once per accepted sample,
// captures the datapath's candidate coefficients and commits them unless
// frozen, saturated or overridden by a pending bank clear.
module anc_adapt_sequencer
    import anc_pkg::*;
#(
    parameter int DATA_BUS_SIZE = DATA_BUS_SIZE_DEF,
    parameter int TAPS          = TAPS_DEF,
    parameter int SAT_LIMIT     = SAT_LIMIT_DEF,
    parameter int ERR_TIMEOUT   = ERR_TIMEOUT_DEF
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            sampleStrobe,
    input  logic                            errorValid,
    input  logic                            freeze,
    input  logic                            coeffClear,
    input  logic                            clearFlags,
    input  logic signed [DATA_BUS_SIZE-1:0] newCoefficient_I     [TAPS],
    input  logic signed [DATA_BUS_SIZE-1:0] newCoefficient_Q     [TAPS],
    output logic signed [DATA_BUS_SIZE-1:0] currentCoefficient_I [TAPS],
    output logic signed [DATA_BUS_SIZE-1:0] currentCoefficient_Q [TAPS],
    output logic                            adaptEnable,
    output logic                            coeffUpdated,
    output logic                            busy,
    output logic                            overrunFlag,
    output logic                            timeoutFlag,
    output logic                            satFlag
);

    localparam int CNT_W = $clog2(ERR_TIMEOUT + 1);

    seq_state_e                      state_r, state_next_s;
    logic [CNT_W-1:0]                cnt_r, cnt_next_s, cnt_inc_s;
    logic signed [DATA_BUS_SIZE-1:0] bank_i_r [TAPS];
    logic signed [DATA_BUS_SIZE-1:0] bank_q_r [TAPS];
    logic signed [DATA_BUS_SIZE-1:0] cand_i_r [TAPS];
    logic signed [DATA_BUS_SIZE-1:0] cand_q_r [TAPS];
    logic                            sat_s, sat_r;
    logic                            clear_pending_r, clear_pending_next_s, clear_now_s;
    logic                            bank_write_s, bank_clear_s;
    logic                            timeout_set_s, sat_set_s, overrun_set_s;
    logic                            adapt_r, updated_r, busy_r;
    logic                            overrun_r, timeout_r, satflag_r;

    anc_coeff_sat_check #(
        .DATA_BUS_SIZE (DATA_BUS_SIZE),
        .TAPS          (TAPS),
        .SAT_LIMIT     (SAT_LIMIT)
    ) u_sat_check (
        .coeff_i   (newCoefficient_I),
        .coeff_q   (newCoefficient_Q),
        .saturated (sat_s)
    );

    assign cnt_inc_s = cnt_r + CNT_W'(1);

    // Next-state and error-timeout counter logic.
    always_comb begin
        state_next_s  = state_r;
        cnt_next_s    = cnt_r;
        timeout_set_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (sampleStrobe) begin
                    state_next_s = WAIT_ERR;
                    cnt_next_s   = '0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT_ERR: begin
                if (errorValid) begin
                    state_next_s = ADAPT;
                end else if (cnt_inc_s == CNT_W'(ERR_TIMEOUT)) begin
                    state_next_s  = IDLE;
                    cnt_next_s    = cnt_inc_s;
                    timeout_set_s = 1'b1;
                end else begin
                    cnt_next_s = cnt_inc_s;
                end
            end
            ADAPT:   state_next_s = CAPTURE;
            CAPTURE: state_next_s = COMMIT;
            COMMIT:  state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Bank write/clear decision; a clear (live or pending) always beats a commit.
    always_comb begin
        bank_write_s = 1'b0;
        bank_clear_s = 1'b0;
        sat_set_s    = 1'b0;
        clear_now_s  = coeffClear | clear_pending_r;
        case (state_r)
            IDLE: begin
                bank_clear_s = clear_now_s;
            end
            COMMIT: begin
                if (clear_now_s) begin
                    bank_clear_s = 1'b1;
                end else if (freeze) begin
                    bank_write_s = 1'b0;
                end else if (sat_r) begin
                    sat_set_s = 1'b1;
                end else begin
                    bank_write_s = 1'b1;
                end
            end
            default: begin
                bank_write_s = 1'b0;
            end
        endcase
        if (bank_clear_s) begin
            clear_pending_next_s = 1'b0;
        end else if (coeffClear) begin
            clear_pending_next_s = 1'b1;
        end else begin
            clear_pending_next_s = clear_pending_r;
        end
        overrun_set_s = sampleStrobe & (state_r != IDLE);
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Registered outputs, sticky flags (set beats clear), capture and bank storage.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_r           <= '0;
            adapt_r         <= 1'b0;
            updated_r       <= 1'b0;
            busy_r          <= 1'b0;
            overrun_r       <= 1'b0;
            timeout_r       <= 1'b0;
            satflag_r       <= 1'b0;
            sat_r           <= 1'b0;
            clear_pending_r <= 1'b0;
            for (int t = 0; t < TAPS; t++) begin
                bank_i_r[t] <= '0;
                bank_q_r[t] <= '0;
                cand_i_r[t] <= '0;
                cand_q_r[t] <= '0;
            end
        end else begin
            cnt_r           <= cnt_next_s;
            adapt_r         <= (state_next_s == ADAPT);
            busy_r          <= (state_next_s != IDLE);
            updated_r       <= bank_write_s | bank_clear_s;
            overrun_r       <= overrun_set_s | (overrun_r & ~clearFlags);
            timeout_r       <= timeout_set_s | (timeout_r & ~clearFlags);
            satflag_r       <= sat_set_s     | (satflag_r & ~clearFlags);
            clear_pending_r <= clear_pending_next_s;
            if (state_r == CAPTURE) begin
                sat_r <= sat_s;
                for (int t = 0; t < TAPS; t++) begin
                    cand_i_r[t] <= newCoefficient_I[t];
                    cand_q_r[t] <= newCoefficient_Q[t];
                end
            end else begin
                sat_r <= sat_r;
            end
            for (int t = 0; t < TAPS; t++) begin
                if (bank_clear_s) begin
                    bank_i_r[t] <= '0;
                    bank_q_r[t] <= '0;
                end else if (bank_write_s) begin
                    bank_i_r[t] <= cand_i_r[t];
                    bank_q_r[t] <= cand_q_r[t];
                end else begin
                    bank_i_r[t] <= bank_i_r[t];
                    bank_q_r[t] <= bank_q_r[t];
                end
            end
        end
    end

    assign currentCoefficient_I = bank_i_r;
    assign currentCoefficient_Q = bank_q_r;
    assign adaptEnable          = adapt_r;
    assign coeffUpdated         = updated_r;
    assign busy                 = busy_r;
    assign overrunFlag          = overrun_r;
    assign timeoutFlag          = timeout_r;
    assign satFlag              = satflag_r;

endmodule

// File: tb/tb_anc_adapt_sequencer.sv
// Scoreboard bench for anc_adapt_sequencer. The driver works per sample
// transaction: from the transaction parameters it predicts the observable
// events (adapt pulse, bank update, end of busy) with their edge numbers
// and queues them; a monitor pops and compares whenever the DUT shows one.
module tb_anc_adapt_sequencer;

    localparam int W     = 11;
    localparam int T     = 3;
    localparam int LIMIT = 1000;
    localparam int TMO   = 15;
    localparam int BW    = 2 * T * W;
    localparam int K_ADAPT = 0;
    localparam int K_UPD   = 1;
    localparam int K_END   = 2;

    logic clock = 1'b0;
    logic reset;
    logic sampleStrobe, errorValid, freeze, coeffClear, clearFlags;
    logic signed [W-1:0] newCoefficient_I [T];
    logic signed [W-1:0] newCoefficient_Q [T];
    logic signed [W-1:0] currentCoefficient_I [T];
    logic signed [W-1:0] currentCoefficient_Q [T];
    logic adaptEnable, coeffUpdated, busy, overrunFlag, timeoutFlag, satFlag;

    anc_adapt_sequencer dut (
        .clock                (clock),
        .reset                (reset),
        .sampleStrobe         (sampleStrobe),
        .errorValid           (errorValid),
        .freeze               (freeze),
        .coeffClear           (coeffClear),
        .clearFlags           (clearFlags),
        .newCoefficient_I     (newCoefficient_I),
        .newCoefficient_Q     (newCoefficient_Q),
        .currentCoefficient_I (currentCoefficient_I),
        .currentCoefficient_Q (currentCoefficient_Q),
        .adaptEnable          (adaptEnable),
        .coeffUpdated         (coeffUpdated),
        .busy                 (busy),
        .overrunFlag          (overrunFlag),
        .timeoutFlag          (timeoutFlag),
        .satFlag              (satFlag)
    );

    always #5 clock = ~clock;

    typedef struct {
        int            kind;
        int            cyc;
        logic [BW-1:0] bank;
        logic [2:0]    flags;
    } exp_t;

    exp_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   cyc        = 0;

    // Reference model state: plain integers, transaction-level rules.
    int cand_i [T];
    int cand_q [T];
    int bank_i_m [T];
    int bank_q_m [T];
    bit ov_m, to_m, sat_m;

    initial forever begin
        @(posedge clock);
        cyc = cyc + 1;
    end

    function automatic logic [BW-1:0] model_bank();
        logic [BW-1:0] p;
        for (int t = 0; t < T; t++) begin
            p[t*W +: W]       = W'(bank_i_m[t]);
            p[(T+t)*W +: W]   = W'(bank_q_m[t]);
        end
        return p;
    endfunction

    function automatic logic [BW-1:0] dut_bank();
        logic [BW-1:0] p;
        for (int t = 0; t < T; t++) begin
            p[t*W +: W]     = currentCoefficient_I[t];
            p[(T+t)*W +: W] = currentCoefficient_Q[t];
        end
        return p;
    endfunction

    function automatic bit any_sat();
        for (int t = 0; t < T; t++) begin
            if ((cand_i[t] < 0 ? -cand_i[t] : cand_i[t]) >= LIMIT) return 1'b1;
            if ((cand_q[t] < 0 ? -cand_q[t] : cand_q[t]) >= LIMIT) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic push(input int kind, input int c);
        exp_t e;
        e.kind  = kind;
        e.cyc   = c;
        e.bank  = model_bank();
        e.flags = {ov_m, to_m, sat_m};
        exp_q.push_back(e);
    endtask

    task automatic model_clear_bank();
        for (int t = 0; t < T; t++) begin
            bank_i_m[t] = 0;
            bank_q_m[t] = 0;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Monitor: every adapt pulse, bank-update pulse and busy fall is checked in order.
    task automatic check_event(input int kind);
        exp_t e;
        bit   ok;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_event: got kind=%0d at cycle %0d, expected no event", kind, cyc);
        end else begin
            e  = exp_q.pop_front();
            ok = (e.kind == kind) && (e.cyc == cyc);
            if (kind != K_ADAPT) ok = ok && (e.bank === dut_bank());
            if (kind == K_END)   ok = ok && (e.flags === {overrunFlag, timeoutFlag, satFlag});
            if (!ok) begin
                miscompares++;
                $display("FAIL event: got kind=%0d cyc=%0d bank=%h flags=%b, expected kind=%0d cyc=%0d bank=%h flags=%b",
                         kind, cyc, dut_bank(), {overrunFlag, timeoutFlag, satFlag},
                         e.kind, e.cyc, e.bank, e.flags);
            end
        end
    endtask

    initial begin : monitor
        bit prev_busy;
        prev_busy = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_busy = 1'b0;
            end else begin
                if (adaptEnable)         check_event(K_ADAPT);
                if (coeffUpdated)        check_event(K_UPD);
                if (prev_busy && !busy)  check_event(K_END);
                prev_busy = busy;
            end
        end
    end

    task automatic apply_cands();
        for (int t = 0; t < T; t++) begin
            newCoefficient_I[t] = W'(cand_i[t]);
            newCoefficient_Q[t] = W'(cand_q[t]);
        end
    endtask

    task automatic set_cands(input int v);
        for (int t = 0; t < T; t++) begin
            cand_i[t] = v;
            cand_q[t] = v;
        end
    endtask

    // One sample transaction. derr: edges from strobe to errorValid (0 = never).
    // ov_off / clr_off: edge offset of a busy strobe / busy coeffClear (0 = none).
    task automatic run_txn(input int derr, input bit frz, input int ov_off, input bit cf_ov,
                           input int clr_off, input bit cws, input bit spur);
        int cs, ce, last, ov_e, clr_e;
        apply_cands();
        cs    = cyc + 1;
        ce    = (derr > 0) ? cs + derr : -100;
        last  = (derr > 0) ? ce + 3 : cs + TMO;
        ov_e  = (ov_off > 0) ? cs + ov_off : -100;
        clr_e = (clr_off > 0 && derr > 0) ? cs + clr_off : -100;
        if (cws) begin
            model_clear_bank();
            push(K_UPD, cs);
        end
        if (ov_off > 0) begin
            if (cf_ov) begin
                to_m  = 1'b0;
                sat_m = 1'b0;
            end
            ov_m = 1'b1;
        end
        if (derr > 0) begin
            push(K_ADAPT, ce);
            if (clr_e > 0) begin
                model_clear_bank();
                push(K_UPD, last);
            end else if (frz) begin
                // bank held, no flag
            end else if (any_sat()) begin
                sat_m = 1'b1;
            end else begin
                bank_i_m = cand_i;
                bank_q_m = cand_q;
                push(K_UPD, last);
            end
        end else begin
            to_m = 1'b1;
        end
        push(K_END, last);
        for (int e = cs; e <= last; e++) begin
            sampleStrobe = (e == cs) || (e == ov_e);
            errorValid   = (e == ce) || (spur && e == ce + 2);
            coeffClear   = (e == clr_e) || (cws && e == cs);
            clearFlags   = cf_ov && (e == ov_e);
            freeze       = (e == last) ? frz : ~frz;
            tick();
        end
        sampleStrobe = 1'b0;
        errorValid   = 1'b0;
        coeffClear   = 1'b0;
        clearFlags   = 1'b0;
        freeze       = 1'b0;
    endtask

    // Idle cycles between samples, optionally clearing flags or the bank.
    task automatic run_gap(input int g, input bit cf, input bit cc);
        for (int i = 0; i < g; i++) begin
            clearFlags = cf && (i == 0);
            coeffClear = cc && (i == 0);
            if (cf && i == 0) begin
                ov_m  = 1'b0;
                to_m  = 1'b0;
                sat_m = 1'b0;
            end
            if (cc && i == 0) begin
                model_clear_bank();
                push(K_UPD, cyc + 1);
            end
            tick();
        end
        clearFlags = 1'b0;
        coeffClear = 1'b0;
        if (cf && g > 0) chk("flags_after_clear", 128'({overrunFlag, timeoutFlag, satFlag}), 128'(3'b000));
    endtask

    task automatic rand_cands();
        int k, c;
        for (int t = 0; t < T; t++) begin
            c = $urandom_range(0, 1998);
            cand_i[t] = c - 999;
            c = $urandom_range(0, 1998);
            cand_q[t] = c - 999;
        end
        if ($urandom_range(0, 3) == 0) begin
            k = $urandom_range(0, 2 * T - 1);
            case ($urandom_range(0, 4))
                0: c = 1000;
                1: c = -1000;
                2: c = -1024;
                3: c = 1023;
                default: c = -1001;
            endcase
            if (k < T) cand_i[k] = c;
            else       cand_q[k - T] = c;
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int derr, span, ov_off, clr_off, ce;
        reset = 1'b1;
        sampleStrobe = 1'b0; errorValid = 1'b0; freeze = 1'b0;
        coeffClear = 1'b0; clearFlags = 1'b0;
        set_cands(0);
        apply_cands();
        model_clear_bank();
        ov_m = 1'b0; to_m = 1'b0; sat_m = 1'b0;
        tick(); tick();
        chk("reset_state", 128'({adaptEnable, coeffUpdated, busy, overrunFlag, timeoutFlag, satFlag, dut_bank()}), 128'(0));
        reset = 1'b0;
        tick();

        // Nominal: I[0]=100, errorValid two edges after the strobe.
        set_cands(0); cand_i[0] = 100;
        run_txn(2, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
        chk("nominal_bank_i0", 128'(currentCoefficient_I[0]), 128'(W'(100)));
        run_gap(1, 1'b0, 1'b0);
        // Saturation guard on Q[2] = -1000, then clear the flags.
        set_cands(7); cand_q[2] = -1000;
        run_txn(1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
        chk("sat_flag_set", 128'(satFlag), 128'(1'b1));
        run_gap(2, 1'b1, 1'b0);
        // Freeze: adapt pulses, bank held.
        set_cands(321);
        run_txn(3, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0);
        // Timeout: no errorValid at all.
        run_txn(0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
        chk("timeout_flag", 128'({timeoutFlag, busy, adaptEnable}), 128'(3'b100));
        run_gap(1, 1'b1, 1'b0);
        // Overrun during WAIT_ERR; commit proceeds.
        set_cands(-55);
        run_txn(3, 1'b0, 1, 1'b0, 0, 1'b0, 1'b0);
        // Clear during ADAPT with candidates of 50.
        set_cands(50);
        run_txn(2, 1'b0, 0, 1'b0, 3, 1'b0, 1'b0);
        chk("clear_busy_sat", 128'(satFlag), 128'(1'b0));
        // Most negative code counts as saturated.
        set_cands(3); cand_i[1] = -1024;
        run_txn(1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
        // Clear and strobe in the same idle cycle; clearFlags meets overrun set.
        set_cands(12);
        run_txn(2, 1'b0, 2, 1'b1, 0, 1'b1, 1'b0);
        run_gap(1, 1'b0, 1'b1);

        // Async reset while in CAPTURE with a non-zero bank.
        set_cands(0); cand_i[0] = 100;
        run_txn(1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
        set_cands(77);
        apply_cands();
        sampleStrobe = 1'b1; tick(); sampleStrobe = 1'b0;
        ce = cyc + 1;
        push(K_ADAPT, ce);
        errorValid = 1'b1; tick(); errorValid = 1'b0;
        tick();
        #1 reset = 1'b1;
        #1 chk("async_reset_capture", 128'({adaptEnable, coeffUpdated, busy, overrunFlag, timeoutFlag, satFlag, dut_bank()}), 128'(0));
        model_clear_bank();
        ov_m = 1'b0; to_m = 1'b0; sat_m = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        set_cands(0); cand_i[1] = -200;
        run_txn(1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);

        // Randomized transactions.
        for (int n = 0; n < 40; n++) begin
            rand_cands();
            derr    = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TMO));
            span    = (derr > 0) ? derr + 3 : TMO;
            ov_off  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, span)) : 0;
            clr_off = (derr > 0 && $urandom_range(0, 6) == 0) ? int'($urandom_range(1, span)) : 0;
            run_txn(derr, ($urandom_range(0, 5) == 0), ov_off,
                    (ov_off > 0) && ($urandom_range(0, 1) == 1), clr_off,
                    ($urandom_range(0, 7) == 0), (derr > 0) && ($urandom_range(0, 1) == 1));
            run_gap($urandom_range(0, 2), ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
        end

        tick(); tick(); tick();
        chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/anc_adapt_sequencer.md
Name: anc_adapt_sequencer

Overview:
Per-sample controller for the ANC LMS adaptation path. Owns the complex coefficient bank (TAPS I/Q pairs) that feeds both the cancelling filter and the coefficient-adaptation datapath. Sequences each sample: wait for the error value, pulse the adaptation enable, capture the updated coefficients, and commit them to the bank. Handles freeze, saturation guard, bank clear and overrun/timeout reporting. Sits between the sample-rate strobe generator and the adaptation datapath.

Parameters:
DATA_BUS_SIZE, 11, signed width of coefficients (Qn.10 fixed point)
TAPS, 3, number of complex taps
SAT_LIMIT, 1000, magnitude limit; a candidate coefficient component with |x| >= SAT_LIMIT blocks the commit
ERR_TIMEOUT, 15, maximum cycles in WAIT_ERR before abort

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high
sampleStrobe  in  1  one-cycle pulse: a new input sample is available
errorValid  in  1  one-cycle pulse: error_I/Q for the current sample is valid
freeze  in  1  level; 1 = keep delay-line alignment but do not commit
coeffClear  in  1  pulse; zero the coefficient bank
clearFlags  in  1  pulse; clear the sticky flags
newCoefficient_I/_Q  in  [TAPS][DATA_BUS_SIZE] signed  candidate coefficients from the adaptation datapath
currentCoefficient_I/_Q  out  [TAPS][DATA_BUS_SIZE] signed  coefficient bank contents
adaptEnable  out  1  sigEnable for the adaptation datapath
coeffUpdated  out  1  one-cycle pulse: bank written this cycle
busy  out  1  FSM is not IDLE
overrunFlag, timeoutFlag, satFlag  out  1 each  sticky status flags

Behaviour:
- Reset (async): FSM=IDLE, bank all zero, adaptEnable=0, coeffUpdated=0, busy=0, all flags=0, timeout counter=0.
- All outputs are registered.
- States:
  - IDLE: on sampleStrobe go to WAIT_ERR and load the timeout counter with 0.
  - WAIT_ERR: on errorValid go to ADAPT. Otherwise increment the counter; when it reaches ERR_TIMEOUT, set timeoutFlag and return to IDLE. No adaptEnable is issued, so the datapath delay line is not shifted.
  - ADAPT: adaptEnable=1 for exactly this one cycle, then go to CAPTURE.
  - CAPTURE: one cycle. The datapath registers newCoefficient at the end of the ADAPT cycle, so newCoefficient is valid here. Evaluate the saturation check, then go to COMMIT.
  - COMMIT: if freeze=0 and the check passed, bank <= newCoefficient and coeffUpdated=1. If the check failed, keep the bank, set satFlag, coeffUpdated=0. If freeze=1, keep the bank, no flag. Return to IDLE.
- Latency: errorValid to adaptEnable is 1 cycle; errorValid to bank write is 3 cycles. sampleStrobe is accepted again in IDLE the cycle after COMMIT. Minimum sample spacing is therefore 5 cycles (sampleStrobe, errorValid on the next cycle, ADAPT, CAPTURE, COMMIT).
- errorValid outside WAIT_ERR is ignored.
- sampleStrobe while busy=1: the sample is dropped, overrunFlag is set, the sequence in progress is unaffected.
- freeze is sampled in the COMMIT cycle only.
- coeffClear:
  - In IDLE: bank <= 0 next cycle, coeffUpdated=1.
  - While busy: the clear is latched as pending. At COMMIT the clear wins over the write (bank=0, coeffUpdated=1, satFlag not set), then pending is cleared.
- coeffClear and sampleStrobe in the same IDLE cycle: the clear is applied and the sample is accepted.
- clearFlags clears all three flags. If clearFlags coincides with a set event, set wins.
- Saturation check: the magnitude test is per component, on all 2*TAPS values. The most negative code counts as saturated.
- Reset mid-sequence: immediate return to IDLE; the bank is zeroed and no partial commit occurs.

Decomposition:
- Shared package anc_pkg:
  - FSM state enum: IDLE, WAIT_ERR, ADAPT, CAPTURE, COMMIT.
  - Coefficient typedef (signed DATA_BUS_SIZE).
  - Default SAT_LIMIT and ERR_TIMEOUT constants.
- One sub-module, anc_coeff_sat_check: combinational check that any of the 2*TAPS candidate values has |x| >= SAT_LIMIT.
- The bank and FSM stay in the top module.

Test Plan:
- Nominal sequence: reset, sampleStrobe, errorValid 2 cycles later, newCoefficient_I[0]=100 available in CAPTURE -> adaptEnable is high exactly 1 cycle (the cycle after errorValid); coeffUpdated pulses 3 cycles after errorValid; currentCoefficient_I[0]=100.
- Saturation guard: candidate newCoefficient_Q[2]=-1000 -> bank unchanged, satFlag=1, coeffUpdated=0. Then clearFlags -> satFlag=0.
- Freeze and timeout: freeze=1 with a full sequence -> adaptEnable pulses once and the bank is unchanged. Then a sampleStrobe with no errorValid -> timeoutFlag set after 15 WAIT_ERR cycles, busy drops, no adaptEnable.
- Overrun: second sampleStrobe during WAIT_ERR -> overrunFlag=1, exactly one adaptEnable pulse, commit proceeds normally.
- Clear while busy: coeffClear during ADAPT with candidates =50 -> at COMMIT the bank is all 0, coeffUpdated=1, satFlag=0.
- Async reset asserted during CAPTURE with bank=100 -> all outputs zero immediately; the next sequence starts cleanly from IDLE.
